// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scanner: column drive patterns, key map,
// commit FSM state encoding and default timing parameters.
package keypad_pkg;

   localparam int unsigned DEF_SCAN_TICKS     = 100000;
   localparam int unsigned DEF_DEBOUNCE_SCANS = 4;

   localparam logic [1:0] StNone  = 2'd0;
   localparam logic [1:0] StHeld  = 2'd1;
   localparam logic [1:0] StMulti = 2'd2;

   // Active-low one-hot drive for each column index.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      logic [3:0] pat;
      case (idx)
         2'd0:    pat = 4'b1110;
         2'd1:    pat = 4'b1101;
         2'd2:    pat = 4'b1011;
         default: pat = 4'b0111;
      endcase
      return pat;
   endfunction

   // Bitmap index is col*4+row.
   function automatic logic [3:0] key_map(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h4;
         4'd2:    code = 4'h7;
         4'd3:    code = 4'h0;
         4'd4:    code = 4'h2;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h8;
         4'd7:    code = 4'hF;
         4'd8:    code = 4'h3;
         4'd9:    code = 4'h6;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hE;
         4'd12:   code = 4'hA;
         4'd13:   code = 4'hB;
         4'd14:   code = 4'hC;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] single_key_code(input logic [15:0] bm);
      logic [3:0] code;
      code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (bm[i]) code = key_map(4'(i));
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      meta_q <= d_i;
      sync_q <= meta_q;
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, frame-level debounce and a commit FSM
// producing key code, valid level, press/release pulses and multi-key flag.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_TICKS     = DEF_SCAN_TICKS,
   parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_press,
   output logic       key_release,
   output logic       multi_key
);

   localparam int unsigned TickW = $clog2(SCAN_TICKS);
   localparam int unsigned StabW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);
   localparam logic [StabW-1:0] StabMax  = StabW'(DEBOUNCE_SCANS);

   logic [3:0]       row_sync;
   logic [TickW-1:0] tick_q, tick_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_q, col_d;
   logic [15:0]      acc_q, acc_d;
   logic [15:0]      prev_q, prev_d;
   logic [StabW-1:0] stable_q, stable_d;
   logic [15:0]      commit_q, commit_d;
   logic [1:0]       state_q, state_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_press_q, key_press_d;
   logic             key_release_q, key_release_d;
   logic             multi_key_q, multi_key_d;

   logic             last_tick;
   logic             frame_end;
   logic             commit;
   logic [15:0]      frame_bm;

   sync2 #(
      .WIDTH(4)
   ) u_row_sync (
      .clk_i(clk),
      .d_i  (row),
      .q_o  (row_sync)
   );

   always_comb begin
      last_tick = (tick_q == TickLast);
      frame_end = last_tick && (col_idx_q == 2'd3);

      // Current column's sample merged into the partial frame.
      frame_bm = acc_q;
      frame_bm[{col_idx_q, 2'b00} +: 4] = ~row_sync;

      tick_d    = last_tick ? '0 : tick_q + TickW'(1);
      col_idx_d = last_tick ? col_idx_q + 2'd1 : col_idx_q;
      col_d     = col_drive(col_idx_d);
      acc_d     = acc_q;
      prev_d    = prev_q;
      stable_d  = stable_q;
      if (last_tick) acc_d = frame_end ? '0 : frame_bm;
      if (frame_end) begin
         prev_d = frame_bm;
         if (frame_bm != prev_q) stable_d = StabW'(1);
         else if (stable_q != StabMax) stable_d = stable_q + StabW'(1);
      end
      commit = frame_end && (stable_d == StabMax) && (frame_bm != commit_q);

      commit_d      = commit_q;
      state_d       = state_q;
      key_code_d    = key_code_q;
      key_valid_d   = key_valid_q;
      multi_key_d   = multi_key_q;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      if (commit) begin
         commit_d      = frame_bm;
         key_release_d = (state_q == StHeld);
         if (frame_bm == 16'h0000) begin
            state_d     = StNone;
            key_valid_d = 1'b0;
            multi_key_d = 1'b0;
         end else if ((frame_bm & (frame_bm - 16'd1)) == 16'h0000) begin
            // A differing single-key bitmap is always a new key.
            state_d     = StHeld;
            key_valid_d = 1'b1;
            multi_key_d = 1'b0;
            key_press_d = 1'b1;
            key_code_d  = single_key_code(frame_bm);
         end else begin
            state_d     = StMulti;
            key_valid_d = 1'b0;
            multi_key_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q        <= '0;
         col_idx_q     <= 2'd0;
         col_q         <= 4'b1110;
         acc_q         <= '0;
         prev_q        <= '0;
         stable_q      <= '0;
         commit_q      <= '0;
         state_q       <= StNone;
         key_code_q    <= 4'h0;
         key_valid_q   <= 1'b0;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
         multi_key_q   <= 1'b0;
      end else begin
         tick_q        <= tick_d;
         col_idx_q     <= col_idx_d;
         col_q         <= col_d;
         acc_q         <= acc_d;
         prev_q        <= prev_d;
         stable_q      <= stable_d;
         commit_q      <= commit_d;
         state_q       <= state_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         multi_key_q   <= multi_key_d;
      end
   end

   assign col         = col_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_press   = key_press_q;
   assign key_release = key_release_q;
   assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: keypad model drives rows from col and a pressed-key bitmap;
// expected values are hand-derived for SCAN_TICKS=4, DEBOUNCE_SCANS=2.
module tb_keypad_scanner;

   localparam logic [15:0] K1 = 16'h0001;
   localparam logic [15:0] K2 = 16'h0010;
   localparam logic [15:0] K5 = 16'h0020;
   localparam logic [15:0] K6 = 16'h0200;
   localparam logic [15:0] K9 = 16'h0400;
   localparam logic [15:0] KE = 16'h0800;
   localparam logic [15:0] KD = 16'h8000;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_press;
   logic        key_release;
   logic        multi_key;
   logic [15:0] keys;

   int n_checks;
   int n_pass;
   int press_cnt;
   int release_cnt;
   int press_base;
   int release_base;

   keypad_scanner #(
      .SCAN_TICKS    (4),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .col        (col),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_press  (key_press),
      .key_release(key_release),
      .multi_key  (multi_key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (!col[c]) begin
            for (int r = 0; r < 4; r++) begin
               if (keys[c*4+r]) row[r] = 1'b0;
            end
         end
      end
   end

   initial begin
      press_cnt   = 0;
      release_cnt = 0;
   end

   always @(posedge clk) begin
      if (key_press) press_cnt <= press_cnt + 1;
      if (key_release) release_cnt <= release_cnt + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      keys     = K5;
      step(3);
      check("reset col", 16'(col), 16'hE);
      check("reset valid", 16'(key_valid), 16'h0);
      check("reset code", 16'(key_code), 16'h0);
      check("reset multi", 16'(multi_key), 16'h0);
      rst = 1'b0;

      // Key 5 held from reset release; commit one cycle after frame 2 end.
      step(1);
      check("col0 held", 16'(col), 16'hE);
      step(3);
      check("col1", 16'(col), 16'hD);
      step(4);
      check("col2", 16'(col), 16'hB);
      step(4);
      check("col3", 16'(col), 16'h7);
      step(4);
      check("col wrap", 16'(col), 16'hE);
      check("no commit after frame1", 16'(key_valid), 16'h0);
      step(15);
      check("press not early", 16'(key_press), 16'h0);
      step(1);
      check("press5 pulse", 16'(key_press), 16'h1);
      check("press5 valid", 16'(key_valid), 16'h1);
      check("press5 code", 16'(key_code), 16'h5);
      check("press5 no release", 16'(key_release), 16'h0);
      keys = 16'h0;
      step(1);
      check("press5 one cycle", 16'(key_press), 16'h0);
      check("press5 count", 16'(press_cnt), 16'd1);

      // Release of key 5.
      step(30);
      check("release not early", 16'(key_release), 16'h0);
      check("valid held", 16'(key_valid), 16'h1);
      step(1);
      check("release5 pulse", 16'(key_release), 16'h1);
      check("release5 valid", 16'(key_valid), 16'h0);
      check("release5 code kept", 16'(key_code), 16'h5);
      check("release5 no press", 16'(key_press), 16'h0);
      step(1);
      check("release5 one cycle", 16'(key_release), 16'h0);

      // Bounce: key D toggles every frame for 6 frames.
      step(15);
      press_base   = press_cnt;
      release_base = release_cnt;
      for (int f = 0; f < 6; f++) begin
         keys = (f % 2 == 0) ? KD : 16'h0;
         step(16);
      end
      check("bounce no press", 16'(press_cnt - press_base), 16'd0);
      check("bounce no release", 16'(release_cnt - release_base), 16'd0);
      check("bounce valid", 16'(key_valid), 16'h0);

      // Keys 1 and 6 together, then release 6.
      keys = K1 | K6;
      step(32);
      check("multi flag", 16'(multi_key), 16'h1);
      check("multi valid", 16'(key_valid), 16'h0);
      check("multi no press", 16'(press_cnt - press_base), 16'd0);
      check("multi no release", 16'(release_cnt - release_base), 16'd0);
      keys = K1;
      step(31);
      check("multi->held not early", 16'(key_press), 16'h0);
      step(1);
      check("multi->held press", 16'(key_press), 16'h1);
      check("multi->held code", 16'(key_code), 16'h1);
      check("multi->held flag", 16'(multi_key), 16'h0);
      check("multi->held valid", 16'(key_valid), 16'h1);

      // Direct key switches: 1 -> 2 -> E.
      keys = K2;
      step(32);
      check("code 2", 16'(key_code), 16'h2);
      keys = KE;
      step(32);
      check("switch press", 16'(key_press), 16'h1);
      check("switch release", 16'(key_release), 16'h1);
      check("switch code", 16'(key_code), 16'hE);

      // Key 9 committed, then reset mid-dwell of col2.
      keys = K9;
      step(32);
      check("code 9", 16'(key_code), 16'h9);
      check("valid 9", 16'(key_valid), 16'h1);
      step(9);
      check("mid col2", 16'(col), 16'hB);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("midrst col", 16'(col), 16'hE);
      check("midrst outputs", {11'h0, key_code, key_valid, key_press, key_release, multi_key},
            16'h0);
      step(31);
      check("repress not early", 16'(key_press), 16'h0);
      step(1);
      check("repress9 pulse", 16'(key_press), 16'h1);
      check("repress9 code", 16'(key_code), 16'h9);
      check("repress9 valid", 16'(key_valid), 16'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
